// File: rtl/hit_judge.sv
// hit_judge: once per frame, sweeps the enemy-bullet pool against the player hitbox.
// It also tracks boss HP, and it drives the collision pulse and the die level for the game-flow FSM.
module hit_judge #(
    parameter int N_BULLET = 32,
    parameter int AW       = 5,
    parameter int CW       = 10,
    parameter int HIT_R    = 4,
    parameter int BOSS_HP  = 100,
    parameter int BOMB_DMG = 2
) (
    input  logic          clk,
    input  logic          hard_reset,
    input  logic          frame_tick,
    input  logic [3:0]    game_state,
    input  logic          game_en,
    input  logic          game_reset,
    input  logic [CW-1:0] player_x,
    input  logic [CW-1:0] player_y,
    input  logic          shot_hit,
    output logic          eb_rd,
    output logic [AW-1:0] eb_addr,
    input  logic          eb_active,
    input  logic [CW-1:0] eb_x,
    input  logic [CW-1:0] eb_y,
    output logic          collision,
    output logic          die,
    output logic [7:0]    boss_hp,
    output logic [AW-1:0] hit_index,
    output logic          scan_busy,
    output logic          scan_overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [3:0] ST_PLAY = 4'b0010;
    localparam logic [3:0] ST_COLL = 4'b1010;
    localparam logic [3:0] ST_BOMB = 4'b0110;

    // Unsigned distance: the larger value minus the smaller, so no wrap can occur.
    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        if (a > b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    logic [1:0]    state_r;
    logic          hit_r;
    logic [AW-1:0] idx_r;
    logic          rd_d_r;
    logic [AW-1:0] addr_d_r;

    logic [CW-1:0] dx_s;
    logic [CW-1:0] dy_s;
    logic          cur_hit_s;
    logic          hit_any_s;
    logic [AW-1:0] idx_final_s;
    logic          start_s;
    logic          shot_ok_s;
    logic          bomb_tick_s;
    logic [8:0]    dmg_s;
    logic [7:0]    hp_next_s;

    // Hit test on the datum returned for the previous read.
    // The DRAIN-cycle datum is folded in directly via hit_any_s.
    always_comb begin
        dx_s = abs_diff(eb_x, player_x);
        dy_s = abs_diff(eb_y, player_y);
        if (rd_d_r && eb_active && (dx_s <= CW'(HIT_R)) && (dy_s <= CW'(HIT_R))) begin
            cur_hit_s = 1'b1;
        end else begin
            cur_hit_s = 1'b0;
        end
        hit_any_s = hit_r | cur_hit_s;
        if (hit_r) begin
            idx_final_s = idx_r;
        end else begin
            idx_final_s = addr_d_r;
        end
    end

    // Scan start qualification and boss damage for this cycle, saturating at zero.
    always_comb begin
        start_s     = frame_tick && game_en && (state_r == S_IDLE);
        shot_ok_s   = shot_hit && game_en && !die &&
                      ((game_state == ST_PLAY) || (game_state == ST_COLL) || (game_state == ST_BOMB));
        bomb_tick_s = frame_tick && game_en && !die && (game_state == ST_BOMB);
        if (bomb_tick_s) begin
            dmg_s = {8'd0, shot_ok_s} + 9'(BOMB_DMG);
        end else begin
            dmg_s = {8'd0, shot_ok_s};
        end
        if ({1'b0, boss_hp} > dmg_s) begin
            hp_next_s = boss_hp - dmg_s[7:0];
        end else begin
            hp_next_s = 8'd0;
        end
    end

    // Scan FSM: read sweep, hit accumulation and the end-of-scan report.
    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            state_r      <= S_IDLE;
            eb_rd        <= 1'b0;
            eb_addr      <= '0;
            collision    <= 1'b0;
            hit_index    <= '0;
            scan_busy    <= 1'b0;
            scan_overrun <= 1'b0;
            hit_r        <= 1'b0;
            idx_r        <= '0;
            rd_d_r       <= 1'b0;
            addr_d_r     <= '0;
        end else if (game_reset) begin
            state_r      <= S_IDLE;
            eb_rd        <= 1'b0;
            eb_addr      <= '0;
            collision    <= 1'b0;
            hit_index    <= '0;
            scan_busy    <= 1'b0;
            scan_overrun <= 1'b0;
            hit_r        <= 1'b0;
            idx_r        <= '0;
            rd_d_r       <= 1'b0;
            addr_d_r     <= '0;
        end else begin
            rd_d_r    <= eb_rd;
            addr_d_r  <= eb_addr;
            collision <= 1'b0;
            if (frame_tick && game_en && scan_busy) begin
                scan_overrun <= 1'b1;
            end
            if (cur_hit_s && !hit_r) begin
                hit_r <= 1'b1;
                idx_r <= addr_d_r;
            end
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        state_r   <= S_SCAN;
                        eb_rd     <= 1'b1;
                        eb_addr   <= '0;
                        scan_busy <= 1'b1;
                        hit_r     <= 1'b0;
                        idx_r     <= '0;
                    end
                end
                S_SCAN: begin
                    if (eb_addr == AW'(N_BULLET - 1)) begin
                        state_r <= S_DRAIN;
                        eb_rd   <= 1'b0;
                    end else begin
                        eb_addr <= eb_addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    // Decision is registered here so collision is high during REPORT.
                    state_r   <= S_REPORT;
                    collision <= hit_any_s && (game_state == ST_PLAY) && game_en && !die;
                    if (hit_any_s) begin
                        hit_index <= idx_final_s;
                    end
                end
                S_REPORT: begin
                    state_r   <= S_IDLE;
                    scan_busy <= 1'b0;
                end
                default: begin
                    state_r   <= S_IDLE;
                    eb_rd     <= 1'b0;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

    // Boss HP and the sticky die level.
    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            boss_hp <= 8'(BOSS_HP);
            die     <= 1'b0;
        end else if (game_reset) begin
            boss_hp <= 8'(BOSS_HP);
            die     <= 1'b0;
        end else begin
            boss_hp <= hp_next_s;
            die     <= die | (boss_hp == 8'd0);
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: a frame-schedule reference model checked every cycle.
// It adds directed scenarios and randomized frames, and pins key points with literal expectations.
module tb_hit_judge;

    localparam int NB = 32;
    localparam logic [3:0] PLAY  = 4'b0010;
    localparam logic [3:0] COLL  = 4'b1010;
    localparam logic [3:0] BOMB  = 4'b0110;
    localparam logic [3:0] OTHER = 4'b0001;

    logic       clk = 1'b0;
    logic       hard_reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] game_state = PLAY;
    logic       game_en = 1'b1;
    logic       game_reset = 1'b0;
    logic [9:0] player_x = 10'd100;
    logic [9:0] player_y = 10'd100;
    logic       shot_hit = 1'b0;
    logic       eb_rd;
    logic [4:0] eb_addr;
    logic       eb_active = 1'b0;
    logic [9:0] eb_x = 10'd0;
    logic [9:0] eb_y = 10'd0;
    logic       collision;
    logic       die;
    logic [7:0] boss_hp;
    logic [4:0] hit_index;
    logic       scan_busy;
    logic       scan_overrun;

    hit_judge dut (
        .clk(clk), .hard_reset(hard_reset), .frame_tick(frame_tick), .game_state(game_state),
        .game_en(game_en), .game_reset(game_reset), .player_x(player_x), .player_y(player_y),
        .shot_hit(shot_hit), .eb_rd(eb_rd), .eb_addr(eb_addr), .eb_active(eb_active),
        .eb_x(eb_x), .eb_y(eb_y), .collision(collision), .die(die), .boss_hp(boss_hp),
        .hit_index(hit_index), .scan_busy(scan_busy), .scan_overrun(scan_overrun)
    );

    always #5 clk = ~clk;

    logic mem_act [NB];
    int   mem_x   [NB];
    int   mem_y   [NB];

    // Bullet pool with a synchronous read port.
    always @(posedge clk) begin
        if (eb_rd) begin
            eb_active <= mem_act[eb_addr];
            eb_x      <= 10'(mem_x[eb_addr]);
            eb_y      <= 10'(mem_y[eb_addr]);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int coll_count = 0;

    // Model state: scan in progress, number of edges since the accepting tick, and the outputs.
    bit m_active = 1'b0;
    int m_k = 0;
    int m_hp = 100;
    bit m_die = 1'b0;
    bit m_ovr = 1'b0;
    bit m_coll = 1'b0;
    int m_hidx = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ad(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int first_hit();
        for (int i = 0; i < NB; i++) begin
            if (mem_act[i] && ad(mem_x[i], int'(player_x)) <= 4 && ad(mem_y[i], int'(player_y)) <= 4)
                return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit old_die;
        int old_hp;
        bit busy;
        int d;
        int fh;
        if (hard_reset || game_reset) begin
            m_active = 1'b0; m_k = 0; m_hp = 100; m_die = 1'b0;
            m_ovr = 1'b0; m_coll = 1'b0; m_hidx = 0;
        end else begin
            old_die = m_die;
            old_hp  = m_hp;
            busy    = m_active;
            d       = 0;
            if (shot_hit && game_en && !old_die &&
                (game_state == PLAY || game_state == COLL || game_state == BOMB)) d += 1;
            if (frame_tick && game_en && !old_die && game_state == BOMB) d += 2;
            m_hp   = (m_hp > d) ? m_hp - d : 0;
            m_die  = old_die || (old_hp == 0);
            m_coll = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == 33) begin
                    fh = first_hit();
                    if (fh >= 0) begin
                        m_hidx = fh;
                        m_coll = (game_state == PLAY) && game_en && !old_die;
                    end
                end
                if (m_k == 34) m_active = 1'b0;
            end
            if (frame_tick && game_en) begin
                if (busy) m_ovr = 1'b1;
                else begin
                    m_active = 1'b1;
                    m_k = 0;
                end
            end
        end
    endtask

    // Every-cycle compare against the model, sampled 1 time unit after the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("eb_rd", int'(eb_rd), int'(m_active && m_k <= 31));
            if (m_active && m_k <= 31) chk("eb_addr", int'(eb_addr), m_k);
            chk("collision", int'(collision), int'(m_coll));
            chk("die", int'(die), int'(m_die));
            chk("boss_hp", int'(boss_hp), m_hp);
            chk("hit_index", int'(hit_index), m_hidx);
            chk("scan_busy", int'(scan_busy), int'(m_active));
            chk("scan_overrun", int'(scan_overrun), int'(m_ovr));
            if (collision) coll_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < NB; i++) begin
            mem_act[i] = 1'b0; mem_x[i] = 0; mem_y[i] = 0;
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y);
        mem_act[i] = 1'b1; mem_x[i] = x; mem_y[i] = y;
    endtask

    // Returns at the negedge just after the edge that captured the tick (edge 0).
    task automatic tick_start();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic pulse_game_reset();
        @(negedge clk); game_reset = 1'b1;
        @(negedge clk); game_reset = 1'b0;
    endtask

    task automatic run_scan(output int pulses);
        int c0;
        c0 = coll_count;
        tick_start();
        repeat (38) @(negedge clk);
        pulses = coll_count - c0;
    endtask

    initial begin
        int p;
        int px;
        int py;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_boss_hp", int'(boss_hp), 100);
        chk("rst_eb_rd", int'(eb_rd), 0);
        hard_reset = 1'b0;
        @(negedge clk);

        // 1: single hit at slot 7, latency and hit_index
        set_slot(7, 103, 97);
        tick_start();
        chk("t1_busy_first", int'(scan_busy), 1);
        repeat (33) @(negedge clk);
        chk("t1_collision", int'(collision), 1);
        chk("t1_hit_index", int'(hit_index), 7);
        @(negedge clk);
        chk("t1_coll_end", int'(collision), 0);
        chk("t1_busy_end", int'(scan_busy), 0);
        repeat (5) @(negedge clk);

        // 2: dx just outside the box, then lowest hitting slot wins
        clear_mem();
        set_slot(7, 105, 100);
        run_scan(p);
        chk("t2_no_hit", p, 0);
        chk("t2_index_kept", int'(hit_index), 7);
        set_slot(3, 96, 104);
        set_slot(7, 103, 97);
        run_scan(p);
        chk("t2_hit", p, 1);
        chk("t2_hit_index", int'(hit_index), 3);

        // 3: no pulse outside Play
        game_state = COLL;
        run_scan(p);
        chk("t3_coll_state", p, 0);
        game_state = BOMB;
        run_scan(p);
        chk("t3_bomb_state", p, 0);
        chk("t3_bomb_hp", int'(boss_hp), 98);
        game_state = PLAY;

        // randomized frames
        for (int it = 0; it < 20; it++) begin
            px = $urandom_range(50, 900);
            py = $urandom_range(50, 900);
            player_x = 10'(px);
            player_y = 10'(py);
            for (int i = 0; i < NB; i++) begin
                mem_act[i] = ($urandom_range(0, 7) == 0);
                mem_x[i]   = px + $urandom_range(0, 16) - 8;
                mem_y[i]   = py + $urandom_range(0, 16) - 8;
            end
            game_state = PLAY;
            game_en = 1'b1;
            tick_start();
            for (int c = 1; c < 45; c++) begin
                @(negedge clk);
                case ($urandom_range(0, 5))
                    0: game_state = COLL;
                    1: game_state = BOMB;
                    2: game_state = OTHER;
                    default: game_state = PLAY;
                endcase
                game_en    = ($urandom_range(0, 7) != 0);
                shot_hit   = ($urandom_range(0, 15) == 0);
                frame_tick = (c >= 5 && c <= 30 && $urandom_range(0, 9) == 0);
            end
            @(negedge clk);
            game_state = PLAY; game_en = 1'b1; shot_hit = 1'b0; frame_tick = 1'b0;
            @(negedge clk);
        end
        pulse_game_reset();
        player_x = 10'd100;
        player_y = 10'd100;

        // 4: HP countdown, combined bomb+shot saturation, die latency
        @(negedge clk); shot_hit = 1'b1;
        repeat (99) @(negedge clk);
        shot_hit = 1'b0;
        chk("t4_hp_1", int'(boss_hp), 1);
        chk("t4_die_0", int'(die), 0);
        game_state = BOMB; frame_tick = 1'b1; shot_hit = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; shot_hit = 1'b0;
        chk("t4_hp_sat", int'(boss_hp), 0);
        chk("t4_die_lag", int'(die), 0);
        @(negedge clk);
        chk("t4_die", int'(die), 1);
        shot_hit = 1'b1;
        @(negedge clk);
        shot_hit = 1'b0;
        chk("t4_hp_hold", int'(boss_hp), 0);
        game_state = PLAY;
        repeat (40) @(negedge clk);

        // 5: overrun and game_reset mid-scan
        pulse_game_reset();
        clear_mem();
        set_slot(7, 103, 97);
        tick_start();
        repeat (9) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("t5_overrun", int'(scan_overrun), 1);
        repeat (9) @(negedge clk);
        p = coll_count;
        game_reset = 1'b1;
        @(negedge clk);
        game_reset = 1'b0;
        chk("t5_eb_rd", int'(eb_rd), 0);
        chk("t5_busy", int'(scan_busy), 0);
        chk("t5_overrun_clr", int'(scan_overrun), 0);
        chk("t5_hp", int'(boss_hp), 100);
        chk("t5_die", int'(die), 0);
        repeat (45) @(negedge clk);
        chk("t5_no_coll", coll_count - p, 0);

        // 6: hard_reset mid-scan with die set
        @(negedge clk); shot_hit = 1'b1;
        repeat (101) @(negedge clk);
        shot_hit = 1'b0;
        chk("t6_die", int'(die), 1);
        tick_start();
        repeat (10) @(negedge clk);
        hard_reset = 1'b1;
        #1;
        chk("t6_rst_eb_rd", int'(eb_rd), 0);
        chk("t6_rst_eb_addr", int'(eb_addr), 0);
        chk("t6_rst_hp", int'(boss_hp), 100);
        chk("t6_rst_die", int'(die), 0);
        chk("t6_rst_busy", int'(scan_busy), 0);
        chk("t6_rst_hit_index", int'(hit_index), 0);
        @(negedge clk);
        hard_reset = 1'b0;
        tick_start();
        chk("t6_restart_rd", int'(eb_rd), 1);
        chk("t6_restart_addr", int'(eb_addr), 0);
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
